cva5_fifo_flex: RTL and testbench

- Parametrised successor to the core's small valid/full FIFOs.
- Supports any depth of 1 or more; depth is not rounded up to a power of two.
- Adds an occupancy count, a programmable almost-full flag, a synchronous flush, optional empty-bypass and optional overflow/underflow protection with sticky error flags.
- Used between issue/execute units and writeback queues where back-pressure must be signalled early and speculative entries must be discarded on a pipeline flush.

---
 rtl/cva5_fifo_flex.sv | 126 ++++++++++++
 tb/tb_cva5_fifo_flex.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cva5_fifo_flex.sv
// rtl/cva5_fifo_flex.sv - flexible-depth FWFT FIFO with count, almost-full, flush, bypass and error flags
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   push, data_in   enqueue request and entry
//   pop             dequeue the head entry
//   flush           discard all contents at the next edge (overrides push/pop)
//   data_out, valid head entry (first-word fall-through) and its qualifier
//   full, almost_full, count   status decoded from the registered occupancy
//   overflow_err, underflow_err sticky illegal-push / illegal-pop flags
module cva5_fifo_flex #(
    parameter int DATA_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 4,
    parameter int ALMOST_FULL_LEVEL = FIFO_DEPTH - 1,
    parameter int BYPASS            = 0,
    parameter int SAFE_MODE         = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic                                 flush,
    input  logic [DATA_WIDTH-1:0]                data_in,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 valid,
    output logic                                 full,
    output logic                                 almost_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 overflow_err,
    output logic                                 underflow_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    logic empty;
    logic pass_through;
    logic push_ok;
    logic pop_ok;
    logic push_eff;
    logic pop_eff;

    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign almost_full = (count >= CW'(ALMOST_FULL_LEVEL));

    // With bypass enabled, a push+pop into an empty FIFO hands the entry
    // straight through; storage, pointers and count are left alone.
    assign pass_through = (BYPASS != 0) && empty && push && pop;

    assign push_ok = !full || pop;
    assign pop_ok  = !empty || ((BYPASS != 0) && push);

    // Legality gating only applies when protection is on; otherwise the
    // request goes through as asked and the flags still record it.
    assign push_eff = push && !flush && !pass_through && (push_ok || (SAFE_MODE == 0));
    assign pop_eff  = pop && !flush && !pass_through && (!empty || (SAFE_MODE == 0));

    assign valid    = !empty || ((BYPASS != 0) && push);
    assign data_out = ((BYPASS != 0) && empty) ? data_in : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (flush) begin
                count <= '0;
            end else begin
                count <= count + CW'(push_eff) - CW'(pop_eff);
            end
            if (push && !push_ok && !flush) begin
                overflow_err <= 1'b1;
            end
            if (pop && !pop_ok && !flush) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_eff && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FIFO_DEPTH == 1) begin : g_single
            assign rd_ptr = '0;
            assign wr_ptr = '0;
        end else begin : g_ptrs
            // Explicit wrap so non-power-of-two depths never alias.
            function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
                return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
            endfunction

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    if (push_eff) begin
                        wr_ptr <= next_ptr(wr_ptr);
                    end
                    if (pop_eff) begin
                        rd_ptr <= next_ptr(rd_ptr);
                    end
                end
            end
        end
    endgenerate

    generate
        if (SAFE_MODE == 0) begin : g_checks
            a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                !(push && full && !pop));
            a_no_underflow : assert property (@(posedge clk) disable iff (rst)
                !(pop && empty && !(push && (BYPASS != 0))));
        end
    endgenerate
endmodule

// File: tb/tb_cva5_fifo_flex.sv
// tb/tb_cva5_fifo_flex.sv - queue-model scoreboard bench for cva5_fifo_flex
module tb_cva5_fifo_flex;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout [3];
    logic       vld [3];
    logic       fl [3];
    logic       af [3];
    logic       ovf [3];
    logic       unf [3];
    logic [2:0] cnt [3];
    logic [0:0] cnt_d1;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Reference model: one queue per instance plus sticky flags.
    logic [7:0] mq [3][$];
    bit         mov [3];
    bit         mun [3];

    function automatic int dep(input int k);
        return (k == 2) ? 1 : 5;
    endfunction
    function automatic int afl(input int k);
        case (k)
            0: return 4;
            1: return 3;
            default: return 1;
        endcase
    endfunction
    function automatic bit byp(input int k);
        return (k == 1);
    endfunction

    cva5_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .ALMOST_FULL_LEVEL(4), .BYPASS(0), .SAFE_MODE(1)) u0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data_in(din),
        .data_out(dout[0]), .valid(vld[0]), .full(fl[0]), .almost_full(af[0]), .count(cnt[0]),
        .overflow_err(ovf[0]), .underflow_err(unf[0]));

    cva5_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .ALMOST_FULL_LEVEL(3), .BYPASS(1), .SAFE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data_in(din),
        .data_out(dout[1]), .valid(vld[1]), .full(fl[1]), .almost_full(af[1]), .count(cnt[1]),
        .overflow_err(ovf[1]), .underflow_err(unf[1]));

    cva5_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(1), .ALMOST_FULL_LEVEL(1), .BYPASS(0), .SAFE_MODE(1)) u2 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data_in(din),
        .data_out(dout[2]), .valid(vld[2]), .full(fl[2]), .almost_full(af[2]), .count(cnt_d1),
        .overflow_err(ovf[2]), .underflow_err(unf[2]));

    assign cnt[2] = {2'b00, cnt_d1};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    // Next-state of the model from the rules, applied at each active edge.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int c;
            bit pass, push_ok, pop_ok;
            c = mq[k].size();
            if (rst) begin
                mq[k].delete();
                mov[k] = 1'b0;
                mun[k] = 1'b0;
            end else if (flush) begin
                mq[k].delete();
            end else begin
                pass    = byp(k) && (c == 0) && push && pop;
                push_ok = push && ((c < dep(k)) || pop);
                pop_ok  = pop && ((c > 0) || (byp(k) && push));
                if (push && !push_ok) mov[k] = 1'b1;
                if (pop && !pop_ok)   mun[k] = 1'b1;
                if (!pass) begin
                    if (pop_ok && c > 0) void'(mq[k].pop_front());
                    if (push_ok) mq[k].push_back(din);
                end
            end
        end
    endtask

    // Monitor: compares every presented output against the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                logic ev;
                c  = mq[k].size();
                ev = (c > 0) || (byp(k) && push);
                chk("count", k, 32'(cnt[k]), 32'(c));
                chk("valid", k, 32'(vld[k]), 32'(ev));
                chk("full", k, 32'(fl[k]), 32'(c == dep(k)));
                chk("almost_full", k, 32'(af[k]), 32'(c >= afl(k)));
                chk("overflow_err", k, 32'(ovf[k]), 32'(mov[k]));
                chk("underflow_err", k, 32'(unf[k]), 32'(mun[k]));
                if (ev) begin
                    chk("data_out", k, 32'(dout[k]), 32'((c > 0) ? mq[k][0] : din));
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit pu, input bit po, input bit f, input logic [7:0] d);
        rst   = r;
        push  = pu;
        pop   = po;
        flush = f;
        din   = d;
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    initial begin
        #1;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);

        // Fill, full replace, overflow, drain through wrap, underflow, flush
        for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 0, 8'(8'h11 * i));
        cyc(0, 1, 1, 0, 8'h66);
        cyc(0, 1, 0, 0, 8'h77);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);

        // Bypass from empty
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'hAB);
        cyc(0, 0, 0, 0, 8'h00);

        // Flush beats push and pop
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'($urandom));
        cyc(0, 1, 1, 1, 8'hCD);
        cyc(0, 1, 0, 0, 8'hEE);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);

        // Depth-1 fill then reset mid-stream
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h01);
        cyc(1, 1, 0, 0, 8'h02);
        cyc(0, 0, 0, 0, 8'h00);

        // Random traffic with shifting push/pop bias
        for (int i = 0; i < 3000; i++) begin
            int pp, pq;
            pp = ((i / 300) % 2 == 0) ? 65 : 35;
            pq = 100 - pp;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < pp,
                $urandom_range(0, 99) < pq,
                $urandom_range(0, 31) == 0,
                8'($urandom));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
